clint_timer: RTL and testbench

//  Parametrised core-local interruptor: shared 64-bit mtime, per-hart mtimecmp and msip.

---
 rtl/clint_timer_pkg.sv | 36 +++
 rtl/clint_timer_prescaler.sv | 57 +++++
 rtl/clint_timer.sv | 177 +++++++++++++++++
 tb/tb_clint_timer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_pkg.sv
// -----------------------------------------------------------------------------
// clint_timer_pkg
//   Shared constants and helpers for the core-local interruptor.
//   - CLINT_BASE     default base address of the block on the MMIO bus
//   - CLINT_*        register offsets from the base address
//   - clint_sel_e    register selected by the address decoder
//   - byte_merge     byte-lane write merge for 64-bit registers
// -----------------------------------------------------------------------------
package clint_timer_pkg;

    localparam logic [63:0] CLINT_BASE      = 64'h0000_0000_0200_0000;
    localparam logic [15:0] CLINT_MSIP      = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP  = 16'h4000;
    localparam logic [15:0] CLINT_TICKDIV   = 16'h8000;
    localparam logic [15:0] CLINT_MTIME     = 16'hBFF8;
    localparam int          CLINT_MAX_HARTS = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_TICKDIV,
        SEL_MTIME
    } clint_sel_e;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int k = 0; k < 8; k++) begin
            res[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// -----------------------------------------------------------------------------
// clint_prescaler
//   Programmable divider that produces the mtime advance strobe.
//   Ports:
//     clk, rst_n    system clock, asynchronous active-low reset
//     div_we        write to the tick_div register this cycle
//     div_strb      byte strobes for the 32-bit divisor
//     div_wdata     write data for the divisor
//     tick_div      current divisor register (for read-back)
//     tick          one-cycle strobe, asserted once every tick_div cycles
// -----------------------------------------------------------------------------
module clint_prescaler #(
    parameter logic [31:0] TICK_DIV = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_we,
    input  logic [3:0]  div_strb,
    input  logic [31:0] div_wdata,
    output logic [31:0] tick_div,
    output logic        tick
);

    logic [31:0] pcnt;
    logic [31:0] div_eff;
    logic [31:0] tick_div_next;

    // A divisor of 0 behaves like 1 (tick every cycle).
    assign div_eff = (tick_div == 32'd0) ? 32'd1 : tick_div;

    // A divisor write restarts the period, so no tick is issued in that cycle.
    assign tick = ~div_we & (pcnt == div_eff - 32'd1);

    always_comb begin
        tick_div_next = tick_div;
        for (int k = 0; k < 4; k++) begin
            if (div_strb[k]) begin
                tick_div_next[8*k +: 8] = div_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_div <= TICK_DIV;
            pcnt     <= 32'd0;
        end else if (div_we) begin
            tick_div <= tick_div_next;
            pcnt     <= 32'd0;
        end else if (tick) begin
            pcnt     <= 32'd0;
        end else begin
            pcnt     <= pcnt + 32'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//   Core-local interruptor: shared 64-bit mtime, per-hart mtimecmp and msip.
//   Ports:
//     clk, rst_n     system clock, asynchronous active-low reset
//     cen_i, wen_i   access enable, 1 = write / 0 = read
//     addr_i         byte address
//     wstrb_i        byte write strobes (lane k = wdata_i[8k+7:8k])
//     wdata_i        write data
//     rdata_o        registered read data, held until the next read
//     rvalid_o       one-cycle pulse the cycle after a read
//     timer_int_o    per-hart MTIP, registered (mtime >= mtimecmp)
//     soft_int_o     per-hart MSIP, straight from the msip bit
// -----------------------------------------------------------------------------
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int          NUM_HARTS = 1,
    parameter logic [63:0] BASE_ADDR = CLINT_BASE,
    parameter logic [31:0] TICK_DIV  = 32'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen_i,
    input  logic                 wen_i,
    input  logic [63:0]          addr_i,
    input  logic [7:0]           wstrb_i,
    input  logic [63:0]          wdata_i,
    output logic [63:0]          rdata_o,
    output logic                 rvalid_o,
    output logic [NUM_HARTS-1:0] timer_int_o,
    output logic [NUM_HARTS-1:0] soft_int_o
);

    logic        wr;
    logic        rd;
    logic        lane_hi;
    logic [63:0] offset;
    logic [15:0] off16;
    logic [15:0] msip_off;
    logic [15:0] cmp_off;
    clint_sel_e  sel;
    logic [2:0]  hart_sel;

    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic [31:0]          tick_div;
    logic                 tick;
    logic                 msip_strb;
    logic                 msip_wbit;
    logic [63:0]          rd_val;

    assign wr      = cen_i & wen_i;
    assign rd      = cen_i & ~wen_i;
    assign lane_hi = addr_i[2];

    // Addresses below the base wrap to a huge offset and decode as unmapped.
    assign offset   = addr_i - BASE_ADDR;
    assign off16    = offset[15:0];
    assign msip_off = off16 - CLINT_MSIP;
    assign cmp_off  = off16 - CLINT_MTIMECMP;

    always_comb begin
        sel      = SEL_NONE;
        hart_sel = 3'd0;
        if (offset[63:16] == 48'd0) begin
            if (off16 == CLINT_MTIME) begin
                sel = SEL_MTIME;
            end else if (off16 == CLINT_TICKDIV) begin
                sel = SEL_TICKDIV;
            end else if (off16 < CLINT_MTIMECMP) begin
                if (msip_off[1:0] == 2'b00 && {2'b00, msip_off[15:2]} < 16'(NUM_HARTS)) begin
                    sel      = SEL_MSIP;
                    hart_sel = msip_off[4:2];
                end
            end else if (cmp_off[2:0] == 3'b000 && {3'b000, cmp_off[15:3]} < 16'(NUM_HARTS)) begin
                sel      = SEL_MTIMECMP;
                hart_sel = cmp_off[5:3];
            end
        end
    end

    // msip is a 32-bit register whose data sits in the upper lanes at a 4-byte offset.
    assign msip_strb = lane_hi ? wstrb_i[4] : wstrb_i[0];
    assign msip_wbit = lane_hi ? wdata_i[32] : wdata_i[0];

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_we    (wr && sel == SEL_TICKDIV),
        .div_strb  (wstrb_i[3:0]),
        .div_wdata (wdata_i[31:0]),
        .tick_div  (tick_div),
        .tick      (tick)
    );

    // A software write wins over the tick; unstrobed bytes keep the pre-tick value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'd0;
        end else if (wr && sel == SEL_MTIME) begin
            mtime <= byte_merge(mtime, wdata_i, wstrb_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [63:0] cmp_q;
        logic        msip_q;
        logic        tint_q;
        logic        hit;

        assign hit = wr && (hart_sel == 3'(h));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmp_q  <= '1;
                msip_q <= 1'b0;
                tint_q <= 1'b0;
            end else begin
                if (hit && sel == SEL_MTIMECMP) begin
                    cmp_q <= byte_merge(cmp_q, wdata_i, wstrb_i);
                end
                if (hit && sel == SEL_MSIP && msip_strb) begin
                    msip_q <= msip_wbit;
                end
                tint_q <= (mtime >= cmp_q);
            end
        end

        assign mtimecmp[h]    = cmp_q;
        assign msip[h]        = msip_q;
        assign timer_int_o[h] = tint_q;
    end

    assign soft_int_o = msip;

    always_comb begin
        rd_val = 64'd0;
        case (sel)
            SEL_MTIME:   rd_val = mtime;
            SEL_TICKDIV: rd_val = {32'd0, tick_div};
            SEL_MTIMECMP: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (hart_sel == 3'(h)) begin
                        rd_val = mtimecmp[h];
                    end
                end
            end
            SEL_MSIP: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (hart_sel == 3'(h)) begin
                        rd_val = lane_hi ? {31'd0, msip[h], 32'd0} : {63'd0, msip[h]};
                    end
                end
            end
            default: rd_val = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o  <= 64'd0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= rd;
            if (rd) begin
                rdata_o <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

    localparam int          NH   = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MTIME   = BASE + 64'hBFF8;
    localparam logic [63:0] A_TICKDIV = BASE + 64'h8000;
    localparam logic [63:0] A_CMP0    = BASE + 64'h4000;

    localparam int K_NONE = 0, K_MSIP = 1, K_CMP = 2, K_DIV = 3, K_MTIME = 4;

    logic          clk;
    logic          rst_n;
    logic          cen_i;
    logic          wen_i;
    logic [63:0]   addr_i;
    logic [7:0]    wstrb_i;
    logic [63:0]   wdata_i;
    logic [63:0]   rdata_o;
    logic          rvalid_o;
    logic [NH-1:0] timer_int_o;
    logic [NH-1:0] soft_int_o;

    int n_checks = 0;
    int n_fail   = 0;

    clint_timer #(
        .NUM_HARTS (NH),
        .BASE_ADDR (BASE),
        .TICK_DIV  (32'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen_i       (cen_i),
        .wen_i       (wen_i),
        .addr_i      (addr_i),
        .wstrb_i     (wstrb_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .timer_int_o (timer_int_o),
        .soft_int_o  (soft_int_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic [31:0]   m_div;
    int unsigned   m_elapsed;   // edges elapsed in the current prescaler period
    logic [63:0]   m_rdata;
    logic          m_rvalid;
    logic [NH-1:0] m_tint;

    task automatic m_reset();
        m_mtime   = 64'd0;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        m_msip    = '0;
        m_div     = 32'd1;
        m_elapsed = 0;
        m_rdata   = 64'd0;
        m_rvalid  = 1'b0;
        m_tint    = '0;
    endtask

    function automatic void m_decode(input logic [63:0] a, output int kind, output int hart);
        logic [63:0] off;
        off  = a - BASE;
        kind = K_NONE;
        hart = 0;
        if (off == 64'hBFF8) kind = K_MTIME;
        else if (off == 64'h8000) kind = K_DIV;
        else if (off >= 64'h4000 && off < 64'h4000 + 64'(8*NH) && off % 8 == 0) begin
            kind = K_CMP;
            hart = int'((off - 64'h4000) / 8);
        end else if (off < 64'(4*NH) && off % 4 == 0) begin
            kind = K_MSIP;
            hart = int'(off / 4);
        end
    endfunction

    function automatic logic [63:0] m_read(input logic [63:0] a);
        int kind, hart;
        m_decode(a, kind, hart);
        case (kind)
            K_MTIME: return m_mtime;
            K_DIV:   return {32'd0, m_div};
            K_CMP:   return m_cmp[hart];
            K_MSIP:  return 64'(m_msip[hart]) << (a[2] ? 32 : 0);
            default: return 64'd0;
        endcase
    endfunction

    // Applies one clock edge worth of architectural behaviour to the model.
    task automatic m_step(input logic cen, input logic wen, input logic [63:0] a,
                          input logic [7:0] s, input logic [63:0] d);
        int          kind, hart;
        logic        wr, div_wr, tick;
        logic [31:0] eff;
        logic [63:0] rv;
        m_decode(a, kind, hart);
        rv     = m_read(a);
        wr     = cen && wen;
        div_wr = wr && kind == K_DIV;
        eff    = (m_div == 0) ? 32'd1 : m_div;
        tick   = !div_wr && (m_elapsed + 1 == eff);
        for (int h = 0; h < NH; h++) m_tint[h] = (m_mtime >= m_cmp[h]);
        m_rvalid = cen && !wen;
        if (m_rvalid) m_rdata = rv;
        if (div_wr || tick) m_elapsed = 0;
        else m_elapsed++;
        if (wr && kind == K_MTIME) begin
            for (int k = 0; k < 8; k++) if (s[k]) m_mtime[8*k +: 8] = d[8*k +: 8];
        end else if (tick) begin
            m_mtime = m_mtime + 1;
        end
        if (div_wr) for (int k = 0; k < 4; k++) if (s[k]) m_div[8*k +: 8] = d[8*k +: 8];
        if (wr && kind == K_CMP)
            for (int k = 0; k < 8; k++) if (s[k]) m_cmp[hart][8*k +: 8] = d[8*k +: 8];
        if (wr && kind == K_MSIP && s[a[2] ? 4 : 0]) m_msip[hart] = d[a[2] ? 32 : 0];
    endtask

    // ---------------- bus driver ----------------
    task automatic cyc(input logic cen, input logic wen, input logic [63:0] a,
                       input logic [7:0] s, input logic [63:0] d);
        cen_i   = cen;
        wen_i   = wen;
        addr_i  = a;
        wstrb_i = s;
        wdata_i = d;
        @(posedge clk);
        m_step(cen, wen, a, s, d);
        @(negedge clk);
        cen_i   = 1'b0;
        wen_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 8'h00, 64'd0);
    endtask

    task automatic wr_reg(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        cyc(1'b1, 1'b1, a, s, d);
    endtask

    task automatic rd_reg(input logic [63:0] a, output logic [63:0] v);
        cyc(1'b1, 1'b0, a, 8'h00, 64'd0);
        v = rdata_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
        n_checks++; if (timer_int_o !== '0) begin n_fail++; $display("FAIL reset_tint got %b want 0", timer_int_o); end
        n_checks++; if (soft_int_o !== '0) begin n_fail++; $display("FAIL reset_sint got %b want 0", soft_int_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_count();
        logic [63:0] v;
        idle(10);
        rd_reg(A_MTIME, v);
        n_checks++; if (v !== m_rdata) begin n_fail++; $display("FAIL idle_mtime got %0d want %0d", v, m_rdata); end
        n_checks++; if (v < 64'd9 || v > 64'd11) begin n_fail++; $display("FAIL idle_mtime_range got %0d want 10+/-1", v); end
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL idle_rvalid got %b want 1", rvalid_o); end
        n_checks++; if (timer_int_o !== '0) begin n_fail++; $display("FAIL idle_tint got %b want 0", timer_int_o); end
        idle(1);
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %b want 0", rvalid_o); end
    endtask

    task automatic test_timer_irq();
        int rise;
        rise = -1;
        wr_reg(A_CMP0, 8'hFF, 64'd20);
        wr_reg(A_MTIME, 8'hFF, 64'd0);
        for (int k = 1; k <= 40 && rise < 0; k++) begin
            idle(1);
            n_checks++;
            if (timer_int_o !== m_tint) begin
                n_fail++; $display("FAIL irq_track cycle %0d got %b want %b", k, timer_int_o, m_tint);
            end
            if (timer_int_o[0] === 1'b1) rise = k;
        end
        n_checks++; if (rise != 21) begin n_fail++; $display("FAIL irq_rise_delay got %0d want 21", rise); end
        wr_reg(A_CMP0, 8'hFF, '1);
        n_checks++; if (timer_int_o[0] !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b want 1", timer_int_o[0]); end
        idle(1);
        n_checks++; if (timer_int_o[0] !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b want 0", timer_int_o[0]); end
    endtask

    task automatic test_prescaler();
        logic [63:0] v, first, r [5];
        wr_reg(A_TICKDIV, 8'h0F, 64'd4);
        first = 64'd0;
        for (int i = 0; i < 17; i++) begin
            rd_reg(A_MTIME, v);
            if (i == 0) first = v;
            n_checks++; if (v !== m_rdata) begin n_fail++; $display("FAIL div4_read %0d got %0d want %0d", i, v, m_rdata); end
        end
        n_checks++; if (v - first !== 64'd4) begin n_fail++; $display("FAIL div4_rate got %0d want 4", v - first); end
        rd_reg(A_TICKDIV, v);
        n_checks++; if (v !== 64'd4) begin n_fail++; $display("FAIL tickdiv_read got %0d want 4", v); end
        wr_reg(A_TICKDIV, 8'h0F, 64'd4);
        for (int i = 0; i < 5; i++) rd_reg(A_MTIME, r[i]);
        n_checks++; if (r[3] !== r[0]) begin n_fail++; $display("FAIL rewrite_no_early got %0d want %0d", r[3], r[0]); end
        n_checks++; if (r[4] !== r[0] + 64'd1) begin n_fail++; $display("FAIL rewrite_tick got %0d want %0d", r[4], r[0] + 64'd1); end
    endtask

    task automatic test_wrap();
        logic [63:0] v;
        logic [63:0] want [3];
        want[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        want[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        want[2] = 64'd0;
        wr_reg(A_TICKDIV, 8'h0F, 64'd1);
        wr_reg(A_CMP0, 8'hFF, 64'd0);
        wr_reg(A_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            rd_reg(A_MTIME, v);
            n_checks++; if (v !== want[i]) begin n_fail++; $display("FAIL wrap_read %0d got %h want %h", i, v, want[i]); end
            n_checks++; if (timer_int_o[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_tint %0d got %b want 1", i, timer_int_o[0]); end
        end
    endtask

    task automatic test_harts();
        logic [63:0] v;
        wr_reg(BASE + 64'h8, 8'h01, 64'd1);
        n_checks++; if (soft_int_o !== 4'b0100) begin n_fail++; $display("FAIL msip2 got %b want 0100", soft_int_o); end
        wr_reg(BASE + 64'h4, 8'h10, 64'h1_0000_0000);
        n_checks++; if (soft_int_o !== 4'b0110) begin n_fail++; $display("FAIL msip1_hi got %b want 0110", soft_int_o); end
        rd_reg(BASE + 64'h4, v);
        n_checks++; if (v !== 64'h1_0000_0000) begin n_fail++; $display("FAIL msip1_read got %h want 100000000", v); end
        wr_reg(BASE + 64'h4018, 8'h0F, 64'h1234_5678_9ABC_DEF0);
        rd_reg(BASE + 64'h4018, v);
        n_checks++; if (v !== 64'hFFFF_FFFF_9ABC_DEF0) begin n_fail++; $display("FAIL cmp3_partial got %h want ffffffff9abcdef0", v); end
        rd_reg(BASE + 64'h4010, v);
        n_checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL cmp2_untouched got %h want all ones", v); end
        wr_reg(BASE + 64'h14, 8'hFF, 64'd1);
        wr_reg(BASE + 64'h4028, 8'hFF, 64'd0);
        n_checks++; if (soft_int_o !== 4'b0110) begin n_fail++; $display("FAIL hart5_write got %b want 0110", soft_int_o); end
        rd_reg(BASE + 64'h4028, v);
        n_checks++; if (v !== 64'd0) begin n_fail++; $display("FAIL hart5_cmp_read got %h want 0", v); end
        rd_reg(BASE + 64'h14, v);
        n_checks++; if (v !== 64'd0) begin n_fail++; $display("FAIL hart5_msip_read got %h want 0", v); end
    endtask

    task automatic test_random();
        logic [15:0] offs [11];
        logic [63:0] a, d;
        logic        cen, wen;
        logic [7:0]  s;
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h4000, 16'h4008,
                 16'h4018, 16'h8000, 16'hBFF8, 16'h4028, 16'h8004};
        for (int i = 0; i < 400; i++) begin
            a   = BASE + 64'(offs[$urandom_range(0, 10)]);
            cen = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) == 1);
            s   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            if (a == A_TICKDIV) d = 64'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 1) d = m_mtime + 64'($urandom_range(0, 6)) - 64'd3;
            else d = {$urandom, $urandom};
            cyc(cen, wen, a, s, d);
            n_checks++; if (rvalid_o !== m_rvalid) begin n_fail++; $display("FAIL rand_rvalid %0d got %b want %b", i, rvalid_o, m_rvalid); end
            n_checks++; if (rdata_o !== m_rdata) begin n_fail++; $display("FAIL rand_rdata %0d got %h want %h", i, rdata_o, m_rdata); end
            n_checks++; if (timer_int_o !== m_tint) begin n_fail++; $display("FAIL rand_tint %0d got %b want %b", i, timer_int_o, m_tint); end
            n_checks++; if (soft_int_o !== m_msip) begin n_fail++; $display("FAIL rand_sint %0d got %b want %b", i, soft_int_o, m_msip); end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        wr_reg(A_CMP0, 8'hFF, 64'd0);
        wr_reg(BASE, 8'h01, 64'd1);
        idle(1);
        cen_i  = 1'b1;
        wen_i  = 1'b0;
        addr_i = A_MTIME;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (timer_int_o !== '0) begin n_fail++; $display("FAIL rstmid_tint got %b want 0", timer_int_o); end
        n_checks++; if (soft_int_o !== '0) begin n_fail++; $display("FAIL rstmid_sint got %b want 0", soft_int_o); end
        n_checks++; if (rdata_o !== 64'd0) begin n_fail++; $display("FAIL rstmid_rdata got %h want 0", rdata_o); end
        @(posedge clk);
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got %b want 0", rvalid_o); end
        @(negedge clk);
        cen_i = 1'b0;
        rst_n = 1'b1;
        m_reset();
        rd_reg(A_MTIME, v);
        n_checks++; if (v !== 64'd0) begin n_fail++; $display("FAIL rstmid_mtime got %h want 0", v); end
        rd_reg(A_CMP0, v);
        n_checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL rstmid_cmp got %h want all ones", v); end
    endtask

    initial begin
        rst_n   = 1'b0;
        cen_i   = 1'b0;
        wen_i   = 1'b0;
        addr_i  = 64'd0;
        wstrb_i = 8'h00;
        wdata_i = 64'd0;
        m_reset();
        test_reset();
        test_idle_count();
        test_timer_irq();
        test_prescaler();
        test_wrap();
        test_harts();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
